// File: rtl/ray_pkg.sv
// Shared definitions for the ray pixel writer: Q8.24 constants, store-bus
// light slice offsets, the writer FSM states and the channel quantiser.
package ray_pkg;

  localparam int FX_FRAC = 24;
  localparam logic signed [31:0] FX_ONE = 32'sh0100_0000;

  localparam int LIGHT_R_LSB = 0;
  localparam int LIGHT_G_LSB = 32;
  localparam int LIGHT_B_LSB = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Clamp to [0,1) and scale the fraction by 255, truncating.
  function automatic logic [7:0] quantise(input logic signed [31:0] v);
    logic [31:0] prod;
    prod = {8'd0, v[FX_FRAC-1:0]} * 32'd255;
    if (v < 0) return 8'd0;
    if (v >= FX_ONE) return 8'd255;
    return prod[31:24];
  endfunction

endpackage

// File: rtl/ray_pixel_writer_if.sv
// Store bus from ray_core (master = core, slave = writer) and the framebuffer
// write port (master = writer, slave = memory).
interface ray_store_if;
  logic [10:0]  store_image_x;
  logic [10:0]  store_image_y;
  logic [479:0] store_diffuse_light_acc;
  logic         output_valid;

  modport master (output store_image_x, store_image_y, store_diffuse_light_acc, output_valid);
  modport slave  (input  store_image_x, store_image_y, store_diffuse_light_acc, output_valid);
endinterface

interface ray_fb_if #(parameter int ADDR_W = 19);
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_data;
  logic              mem_valid;
  logic              mem_ready;

  modport master (output mem_addr, mem_data, mem_valid, input mem_ready);
  modport slave  (input  mem_addr, mem_data, mem_valid, output mem_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head data and a synchronous flush.
// A push while full is only taken if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the head so an idle port shows zeros rather than stale entries.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ray_pixel_writer.sv
// Accepts finished pixels from the ray core, quantises to RGB888, forms the
// framebuffer address and queues writes toward a valid/ready memory port.
module ray_pixel_writer
  import ray_pkg::*;
#(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  ray_store_if.slave        store,
  ray_fb_if.master          mem,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              range_err,
  output logic [ADDR_W-1:0] pixel_count
);
  localparam int PIX_TOTAL = IMAGE_W * IMAGE_H;
  localparam int FW        = ADDR_W + 24;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              s1_valid_q, s2_valid_q;
  logic [10:0]       s1_x_q, s1_y_q;
  logic [23:0]       s1_rgb_q, s2_rgb_q;
  logic [ADDR_W-1:0] s2_addr_q, pixel_count_q;
  logic              overflow_q, range_err_q;
  logic              accept, in_range, take, bad, pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_rdata;
  logic [23:0]       rgb_in;
  logic [ADDR_W-1:0] addr_s1;
  logic              unused_bits;

  assign unused_bits = ^{store.store_diffuse_light_acc[479:96], fifo_count};

  assign accept   = (state_q == ST_RUN) && store.output_valid && !frame_start;
  assign in_range = (32'(store.store_image_x) < IMAGE_W) && (32'(store.store_image_y) < IMAGE_H);
  assign take     = accept && in_range;
  assign bad      = accept && !in_range;

  assign rgb_in = {quantise(store.store_diffuse_light_acc[LIGHT_R_LSB +: 32]),
                   quantise(store.store_diffuse_light_acc[LIGHT_G_LSB +: 32]),
                   quantise(store.store_diffuse_light_acc[LIGHT_B_LSB +: 32])};
  assign addr_s1 = ADDR_W'(s1_y_q) * ADDR_W'(IMAGE_W) + ADDR_W'(s1_x_q);

  assign pop           = mem.mem_valid && mem.mem_ready;
  assign mem.mem_valid = !fifo_empty;
  assign mem.mem_addr  = fifo_rdata[FW-1:24];
  assign mem.mem_data  = fifo_rdata[23:0];

  assign busy        = (state_q != ST_IDLE);
  assign overflow    = overflow_q;
  assign range_err   = range_err_q;
  assign pixel_count = pixel_count_q;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_RUN:
        if (take && (int'(pixel_count_q) + 1 == PIX_TOTAL)) state_d = ST_DRAIN;
      ST_DRAIN:
        if (!s1_valid_q && !s2_valid_q && fifo_empty) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      default: ;
    endcase
    if (frame_start) begin
      state_d    = ST_RUN;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      s1_valid_q    <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_rgb_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_addr_q     <= '0;
      s2_rgb_q      <= '0;
      pixel_count_q <= '0;
      overflow_q    <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start) begin
        s1_valid_q    <= 1'b0;
        s2_valid_q    <= 1'b0;
        pixel_count_q <= '0;
        overflow_q    <= 1'b0;
        range_err_q   <= 1'b0;
      end else begin
        s1_valid_q <= take;
        if (take) begin
          s1_x_q   <= store.store_image_x;
          s1_y_q   <= store.store_image_y;
          s1_rgb_q <= rgb_in;
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_addr_q <= addr_s1;
          s2_rgb_q  <= s1_rgb_q;
        end
        if (take) pixel_count_q <= pixel_count_q + ADDR_W'(1);
        if (bad) range_err_q <= 1'b1;
        // The pixel is already counted; only the write is lost.
        if (s2_valid_q && fifo_full && !pop) overflow_q <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (s2_valid_q),
    .pop   (pop),
    .wdata ({s2_addr_q, s2_rgb_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: doc/ray_pixel_writer.md
# ray_pixel_writer

Consumer end of the `ray_core` store interface. It accepts finished pixels (`store_image_x/y`, `store_diffuse_light_acc`, `output_valid`) at up to one per clock with no backpressure. Each pixel's Q8.24 light vector is clamped and quantised to RGB888, the framebuffer address `y*IMAGE_W + x` is formed, and the write is queued in a FIFO toward a valid/ready framebuffer memory port. It also tracks frame completion, raises `frame_done`, and flags dropped or out-of-range pixels.

## Interface
- `IMAGE_W`, 640, image width in pixels
- `IMAGE_H`, 480, image height in pixels
- `ADDR_W`, 19, framebuffer word address width; must satisfy 2^ADDR_W ≥ IMAGE_W*IMAGE_H
- `FIFO_DEPTH`, 16, write-FIFO entries, power of two
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `frame_start`  in  1  one-cycle pulse; arms a new frame
- `store_image_x`  in  11  pixel column
- `store_image_y`  in  11  pixel row
- `store_diffuse_light_acc`  in  480  only bits [95:0] are used: R=[31:0], G=[63:32], B=[95:64], each signed Q8.24
- `output_valid`  in  1  store-bus valid; one pixel per asserted cycle
- `mem_addr`  out  ADDR_W  framebuffer word address
- `mem_data`  out  24  {R[23:16], G[15:8], B[7:0]}
- `mem_valid`  out  1  write request
- `mem_ready`  in  1  write accepted when both `mem_valid` and `mem_ready` are high
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle completion pulse
- `overflow`  out  1  sticky: a pixel was dropped because the FIFO was full
- `range_err`  out  1  sticky: a pixel arrived with x ≥ IMAGE_W or y ≥ IMAGE_H
- `pixel_count`  out  ADDR_W  number of in-range pixels received in the current frame

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `output_valid` is ignored.
  - `frame_start` in any state: flush the pipeline and FIFO, clear `pixel_count`, `overflow` and `range_err`, go to RUN.
  - RUN: every in-range valid pixel increments `pixel_count`. When `pixel_count` reaches IMAGE_W*IMAGE_H, go to DRAIN. Valid pixels arriving in DRAIN are ignored.
  - DRAIN: when the pipeline and FIFO are both empty, pulse `frame_done` for one cycle and go to IDLE.
- Channel quantisation, per channel v:
  - v < 0 → 0
  - v ≥ 0x0100_0000 → 255
  - otherwise (v[23:0]*255) >> 24, i.e. truncation (0.5 → 127)
- Address: `y*IMAGE_W + x`, computed as an unsigned ADDR_W-bit product. Out-of-range pixels set `range_err` and are discarded: not counted, not written.
- Pipeline:
  - S1 registers the input and clamps/quantises.
  - S2 computes the address and pushes into the FIFO.
  - The pipeline never stalls.
- FIFO:
  - Push when full with no pop in the same cycle: the pixel is dropped and `overflow` is set. The dropped pixel is still counted.
  - Simultaneous push and pop when full: legal, nothing is lost.
  - Pixels leave the FIFO in arrival order.
- Memory port:
  - `mem_valid` = FIFO not empty; the head entry drives `mem_addr` and `mem_data`.
  - While `mem_valid` is high and `mem_ready` is low, `mem_addr` and `mem_data` must hold stable.

## Timing
- Reset values: state IDLE; `mem_valid`, `busy`, `frame_done`, `overflow`, `range_err` = 0; `pixel_count`, `mem_addr`, `mem_data` = 0; FIFO empty.
- Latency: a pixel valid at cycle N, with the FIFO empty, gives `mem_valid` = 1 at cycle N+3.
- Throughput: one pixel per clock while `mem_ready` stays high.
- `frame_done` is asserted the cycle after the last memory handshake of the frame.
- If `frame_start` and `output_valid` coincide, the pixel is discarded and the new frame begins.
- Reset asserted mid-frame clears everything asynchronously. The framebuffer is not restored.

## Structure
- Shared package `ray_pkg` holds:
  - Q8.24 constants: FX_ONE = 2^24, FX_FRAC = 24.
  - Store-bus slice offsets: LIGHT_R/G/B_LSB.
  - The FSM state enum.
- One sub-module, `sync_fifo`, parameterised on width and depth, with full, empty and count outputs.
- The quantiser is a function in `ray_pkg`.

## Test plan
- Reset check: hold `rst` low, then release → all outputs zero. `output_valid` in IDLE produces no `mem_valid`.
- Single pixel: `frame_start`, then x=3, y=2, R=0x0080_0000, G=0xFFFF_FFFF, B=0x0100_0000 → at N+3, `mem_addr`=1283, `mem_data`=0x7F00FF, `pixel_count`=1.
- Backpressure: hold `mem_ready`=0 and send FIFO_DEPTH+3 back-to-back pixels → exactly 3 dropped, `overflow`=1. On raising `mem_ready`, FIFO_DEPTH writes emerge in order with stable data throughout the stall.
- Full frame with IMAGE_W=4, IMAGE_H=2: 8 pixels → DRAIN, one `frame_done` pulse after the 8th handshake, `busy`=0, then IDLE.
- Out of range: x=640, y=0 with default parameters → `range_err`=1, no write, `pixel_count` unchanged.
- Restart: `frame_start` mid-frame with 5 pixels queued → FIFO flushed, `pixel_count`=0, no stale writes.
